// File: rtl/nco_phase_accumulator.sv
// nco_phase_accumulator
// Phase accumulator stage of the NCO. A new phase increment is taken over a
// valid/ready handshake into a shadow register. It moves into the active
// register only at a safe point: a wrap, an idle (enable low) cycle, or while
// the active increment is zero. This keeps frequency changes glitch-free.
// Outputs are truncated phase, a square wave (accumulator MSB) and a one-cycle
// wrap strobe.
//
// Optional build macro: NCO_DITHER_EN
//   Adds a 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1).
//   Its low bits are added below the truncation point of phase_out only.
//   acc, square_out and wrap_pulse are not affected.
module nco_phase_accumulator #(
  parameter int INC_WIDTH   = 13,
  parameter int ACC_WIDTH   = 24,
  parameter int PHASE_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [INC_WIDTH-1:0]   inc_in,
  input  logic                   inc_valid,
  output logic                   inc_ready,
  output logic [PHASE_WIDTH-1:0] phase_out,
  output logic                   square_out,
  output logic                   wrap_pulse
);

  localparam int DITH_WIDTH = ACC_WIDTH - PHASE_WIDTH;

  logic [ACC_WIDTH-1:0] acc_r;
  logic [INC_WIDTH-1:0] active_inc_r;
  logic [INC_WIDTH-1:0] shadow_inc_r;
  logic                 pending_r;
  logic                 wrap_r;

  logic [ACC_WIDTH:0]   sum_s;
  logic                 carry_s;
  logic                 accept_s;
  logic                 commit_s;

  // Adder with an extra bit so that the carry-out is visible.
  assign sum_s    = {1'b0, acc_r} + {{(ACC_WIDTH + 1 - INC_WIDTH){1'b0}}, active_inc_r};
  assign carry_s  = enable & sum_s[ACC_WIDTH];

  // A handshake is possible only while the shadow register is empty.
  assign accept_s = inc_valid & ~pending_r;

  // Commit the shadow value at a wrap, while idle, or while the active step is zero.
  assign commit_s = pending_r &
                    (carry_s | ~enable | (active_inc_r == {INC_WIDTH{1'b0}}));

  // Accumulator, increment double-buffer and wrap strobe registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_r        <= {ACC_WIDTH{1'b0}};
      active_inc_r <= {INC_WIDTH{1'b0}};
      shadow_inc_r <= {INC_WIDTH{1'b0}};
      pending_r    <= 1'b0;
      wrap_r       <= 1'b0;
    end else begin
      if (enable) begin
        acc_r <= sum_s[ACC_WIDTH-1:0];
      end else begin
        acc_r <= acc_r;
      end
      wrap_r <= carry_s;
      // Accept and commit are mutually exclusive: accept needs pending low.
      if (accept_s) begin
        shadow_inc_r <= inc_in;
        pending_r    <= 1'b1;
      end else if (commit_s) begin
        active_inc_r <= shadow_inc_r;
        pending_r    <= 1'b0;
      end else begin
        shadow_inc_r <= shadow_inc_r;
        pending_r    <= pending_r;
      end
    end
  end

  assign inc_ready  = ~pending_r;
  assign square_out = acc_r[ACC_WIDTH-1];
  assign wrap_pulse = wrap_r;

`ifdef NCO_DITHER_EN
  logic [15:0]          lfsr_r;
  logic                 lfsr_fb_s;
  logic [ACC_WIDTH-1:0] dith_sum_s;

  // Feedback taps for x^16+x^14+x^13+x^11+1.
  assign lfsr_fb_s = lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10];

  // Dither LFSR advances once per enabled cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_r <= 16'hACE1;
    end else if (enable) begin
      lfsr_r <= {lfsr_r[14:0], lfsr_fb_s};
    end else begin
      lfsr_r <= lfsr_r;
    end
  end

  // Dither sits entirely below the truncation point, so it moves phase by at most one code.
  assign dith_sum_s = acc_r + {{PHASE_WIDTH{1'b0}}, lfsr_r[DITH_WIDTH-1:0]};
  assign phase_out  = dith_sum_s[ACC_WIDTH-1 -: PHASE_WIDTH];
`else
  assign phase_out  = acc_r[ACC_WIDTH-1 -: PHASE_WIDTH];
`endif

endmodule

// File: tb/tb_nco_phase_accumulator.sv
// Directed testbench for nco_phase_accumulator (default parameters).
module tb_nco_phase_accumulator;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [12:0] inc_in;
  logic        inc_valid;
  logic        inc_ready;
  logic [7:0]  phase_out;
  logic        square_out;
  logic        wrap_pulse;

  int tests;
  int fails;

  nco_phase_accumulator dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .inc_in     (inc_in),
    .inc_valid  (inc_valid),
    .inc_ready  (inc_ready),
    .phase_out  (phase_out),
    .square_out (square_out),
    .wrap_pulse (wrap_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset, then hand over one increment; commit happens on the next edge because active is zero.
  task automatic load_fresh(input logic [12:0] inc);
    reset = 1'b1; enable = 1'b0; inc_valid = 1'b0; inc_in = 13'd0;
    tick(); tick();
    reset = 1'b0; enable = 1'b1; inc_in = inc; inc_valid = 1'b1;
    tick();
    inc_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; inc_valid = 1'b1; inc_in = 13'd123;
    tick(); tick(); tick();
    tests++; if (phase_out !== 8'd0) begin fails++; $display("FAIL rst_phase: got %0d expected 0", phase_out); end
    tests++; if (square_out !== 1'b0) begin fails++; $display("FAIL rst_square: got %0b expected 0", square_out); end
    tests++; if (wrap_pulse !== 1'b0) begin fails++; $display("FAIL rst_wrap: got %0b expected 0", wrap_pulse); end
    tests++; if (inc_ready !== 1'b1) begin fails++; $display("FAIL rst_ready: got %0b expected 1", inc_ready); end
    reset = 1'b0; inc_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      tests++; if (phase_out !== 8'd0) begin fails++; $display("FAIL rst_hold_phase: got %0d expected 0", phase_out); end
      tests++; if (inc_ready !== 1'b1) begin fails++; $display("FAIL rst_hold_ready: got %0b expected 1", inc_ready); end
      tests++; if (wrap_pulse !== 1'b0) begin fails++; $display("FAIL rst_hold_wrap: got %0b expected 0", wrap_pulse); end
    end
  endtask

  task automatic test_constant_4096();
    logic [23:0] e;
    load_fresh(13'd4096);
    tests++; if (phase_out !== 8'd0) begin fails++; $display("FAIL c4096_commit_phase: got %0d expected 0", phase_out); end
    tests++; if (inc_ready !== 1'b1) begin fails++; $display("FAIL c4096_commit_ready: got %0b expected 1", inc_ready); end
    for (int k = 1; k <= 8192; k++) begin
      tick();
      e = 24'(k * 4096);
      tests++; if (phase_out !== e[23:16]) begin fails++; if (fails < 40) $display("FAIL c4096_phase k=%0d: got %0d expected %0d", k, phase_out, e[23:16]); end
      tests++; if (square_out !== e[23]) begin fails++; if (fails < 40) $display("FAIL c4096_square k=%0d: got %0b expected %0b", k, square_out, e[23]); end
      tests++; if (wrap_pulse !== ((k % 4096) == 0)) begin fails++; if (fails < 40) $display("FAIL c4096_wrap k=%0d: got %0b expected %0b", k, wrap_pulse, ((k % 4096) == 0)); end
    end
  endtask

  task automatic test_change_mid_period();
    logic [23:0] e;
    load_fresh(13'd4096);
    for (int k = 1; k <= 1000; k++) tick();
    inc_in = 13'd2441; inc_valid = 1'b1;
    tick();
    inc_valid = 1'b0;
    tests++; if (inc_ready !== 1'b0) begin fails++; $display("FAIL mid_ready_low: got %0b expected 0", inc_ready); end
    for (int k = 1002; k <= 4096; k++) begin
      tick();
      e = 24'(k * 4096);
      tests++; if (phase_out !== e[23:16]) begin fails++; if (fails < 40) $display("FAIL mid_old_phase k=%0d: got %0d expected %0d", k, phase_out, e[23:16]); end
      tests++; if (inc_ready !== (k == 4096)) begin fails++; if (fails < 40) $display("FAIL mid_ready k=%0d: got %0b expected %0b", k, inc_ready, (k == 4096)); end
      tests++; if (wrap_pulse !== (k == 4096)) begin fails++; if (fails < 40) $display("FAIL mid_wrap k=%0d: got %0b expected %0b", k, wrap_pulse, (k == 4096)); end
    end
    // 6873*2441 < 2^24 < 6874*2441, so the next wrap lands on step 6874.
    for (int j = 1; j <= 7000; j++) begin
      tick();
      e = 24'(j * 2441);
      tests++; if (phase_out !== e[23:16]) begin fails++; if (fails < 40) $display("FAIL mid_new_phase j=%0d: got %0d expected %0d", j, phase_out, e[23:16]); end
      tests++; if (wrap_pulse !== (j == 6874)) begin fails++; if (fails < 40) $display("FAIL mid_new_wrap j=%0d: got %0b expected %0b", j, wrap_pulse, (j == 6874)); end
    end
  endtask

  task automatic test_handshake_on_carry();
    logic [23:0] e;
    load_fresh(13'd4096);
    for (int k = 1; k <= 4095; k++) tick();
    inc_in = 13'd2441; inc_valid = 1'b1;
    tick();
    inc_valid = 1'b0;
    tests++; if (wrap_pulse !== 1'b1) begin fails++; $display("FAIL hoc_wrap: got %0b expected 1", wrap_pulse); end
    tests++; if (inc_ready !== 1'b0) begin fails++; $display("FAIL hoc_ready: got %0b expected 0", inc_ready); end
    for (int k = 4097; k <= 8192; k++) begin
      tick();
      e = 24'(k * 4096);
      tests++; if (phase_out !== e[23:16]) begin fails++; if (fails < 40) $display("FAIL hoc_old_phase k=%0d: got %0d expected %0d", k, phase_out, e[23:16]); end
      tests++; if (inc_ready !== (k == 8192)) begin fails++; if (fails < 40) $display("FAIL hoc_ready k=%0d: got %0b expected %0b", k, inc_ready, (k == 8192)); end
      tests++; if (wrap_pulse !== (k == 8192)) begin fails++; if (fails < 40) $display("FAIL hoc_wrap k=%0d: got %0b expected %0b", k, wrap_pulse, (k == 8192)); end
    end
    for (int j = 1; j <= 100; j++) begin
      tick();
      e = 24'(j * 2441);
      tests++; if (phase_out !== e[23:16]) begin fails++; if (fails < 40) $display("FAIL hoc_new_phase j=%0d: got %0d expected %0d", j, phase_out, e[23:16]); end
    end
  endtask

  task automatic test_idle_and_reset();
    logic [23:0] e;
    load_fresh(13'd4096);
    for (int k = 1; k <= 100; k++) tick();
    // acc = 409600 -> phase 6
    enable = 1'b0; inc_in = 13'd2441; inc_valid = 1'b1;
    tick();
    inc_valid = 1'b0;
    tests++; if (inc_ready !== 1'b0) begin fails++; $display("FAIL idle_ready_low: got %0b expected 0", inc_ready); end
    tests++; if (phase_out !== 8'd6) begin fails++; $display("FAIL idle_phase0: got %0d expected 6", phase_out); end
    for (int i = 0; i < 9; i++) begin
      tick();
      tests++; if (inc_ready !== 1'b1) begin fails++; $display("FAIL idle_commit i=%0d: got %0b expected 1", i, inc_ready); end
      tests++; if (phase_out !== 8'd6) begin fails++; $display("FAIL idle_frozen i=%0d: got %0d expected 6", i, phase_out); end
      tests++; if (wrap_pulse !== 1'b0) begin fails++; $display("FAIL idle_wrap i=%0d: got %0b expected 0", i, wrap_pulse); end
    end
    enable = 1'b1;
    for (int j = 1; j <= 50; j++) begin
      tick();
      e = 24'(409600 + j * 2441);
      tests++; if (phase_out !== e[23:16]) begin fails++; $display("FAIL idle_resume j=%0d: got %0d expected %0d", j, phase_out, e[23:16]); end
    end
    inc_in = 13'd1000; inc_valid = 1'b1;
    tick();
    inc_valid = 1'b0;
    tests++; if (inc_ready !== 1'b0) begin fails++; $display("FAIL rstmid_pending: got %0b expected 0", inc_ready); end
    reset = 1'b1; inc_valid = 1'b1; inc_in = 13'd500;
    tick();
    tests++; if (phase_out !== 8'd0) begin fails++; $display("FAIL rstmid_phase: got %0d expected 0", phase_out); end
    tests++; if (square_out !== 1'b0) begin fails++; $display("FAIL rstmid_square: got %0b expected 0", square_out); end
    tests++; if (wrap_pulse !== 1'b0) begin fails++; $display("FAIL rstmid_wrap: got %0b expected 0", wrap_pulse); end
    tests++; if (inc_ready !== 1'b1) begin fails++; $display("FAIL rstmid_ready: got %0b expected 1", inc_ready); end
    reset = 1'b0; inc_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      tests++; if (phase_out !== 8'd0) begin fails++; $display("FAIL rstmid_discard i=%0d: got %0d expected 0", i, phase_out); end
      tests++; if (inc_ready !== 1'b1) begin fails++; $display("FAIL rstmid_ready_after i=%0d: got %0b expected 1", i, inc_ready); end
    end
  endtask

`ifdef NCO_DITHER_EN
  task automatic test_dither();
    logic [23:0] e;
    logic [7:0]  d;
    load_fresh(13'd4096);
    for (int k = 1; k <= 4200; k++) begin
      tick();
      e = 24'(k * 4096);
      d = phase_out - e[23:16];
      tests++; if (d > 8'd1) begin fails++; if (fails < 40) $display("FAIL dith_phase k=%0d: got %0d expected %0d or +1", k, phase_out, e[23:16]); end
      tests++; if (wrap_pulse !== ((k % 4096) == 0)) begin fails++; if (fails < 40) $display("FAIL dith_wrap k=%0d: got %0b expected %0b", k, wrap_pulse, ((k % 4096) == 0)); end
      tests++; if (square_out !== e[23]) begin fails++; if (fails < 40) $display("FAIL dith_square k=%0d: got %0b expected %0b", k, square_out, e[23]); end
    end
  endtask
`endif

  initial begin
    tests = 0; fails = 0;
    reset = 1'b1; enable = 1'b0; inc_valid = 1'b0; inc_in = 13'd0;
    test_reset();
    test_constant_4096();
    test_change_mid_period();
    test_handshake_on_carry();
    test_idle_and_reset();
`ifdef NCO_DITHER_EN
    test_dither();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/nco_phase_accumulator.md
# nco_phase_accumulator

Phase accumulator stage of the NCO, directly downstream of the Prescaler. It takes the Prescaler's 13-bit phase increment through a valid/ready handshake and double-buffers it. The new increment is applied only at a phase wrap, so frequency changes are glitch-free. Each enabled cycle it advances a wide accumulator and drives truncated phase, a square wave and a wrap strobe to the waveform stage.

## Interface
- INC_WIDTH, 13, increment width; matches the Prescaler result width (Prescaler width + 1).
- ACC_WIDTH, 24, accumulator width; must satisfy ACC_WIDTH > INC_WIDTH.
- PHASE_WIDTH, 8, truncated phase output width; ACC_WIDTH - PHASE_WIDTH must be ≤ 16.

- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  reset, synchronous, active-high.
- enable  input  1  advance the accumulator this cycle.
- inc_in  input  INC_WIDTH  phase increment from the Prescaler result.
- inc_valid  input  1  inc_in is valid.
- inc_ready  output  1  shadow register empty; can accept an increment.
- phase_out  output  PHASE_WIDTH  truncated phase.
- square_out  output  1  accumulator MSB.
- wrap_pulse  output  1  one-cycle strobe on accumulator carry-out.

## Operation
- State registers:
  - acc[ACC_WIDTH-1:0]
  - active_inc (increment in use)
  - shadow_inc
  - pending flag
- Accept: inc_valid && inc_ready loads shadow_inc <= inc_in and sets pending.
- inc_ready = !pending (combinational). No other ready dependency.
- Accumulate: when enable = 1, acc <= acc + zero-extended active_inc, modulo 2^ACC_WIDTH. When enable = 0, acc holds.
- Carry = carry-out of that addition, qualified by enable.
- Commit: when pending = 1 and any of the following holds, set active_inc <= shadow_inc and clear pending:
  - carry this cycle, or
  - enable = 0, or
  - active_inc = 0.
- The commit cycle's addition still uses the old active_inc. The new value is used from the next cycle.
- Handshake in the same cycle as a carry, with pending = 0: the value goes to shadow and commits at the next qualifying event, not this carry.
- Handshake and commit never coincide, because ready requires !pending.
- Outputs are derived from registered state:
  - phase_out = acc[ACC_WIDTH-1 -: PHASE_WIDTH]
  - square_out = acc[ACC_WIDTH-1]
  - wrap_pulse is registered carry.
- Reset mid-operation: all state returns to reset values in one cycle. A pending shadow value is discarded. inc_valid is ignored while reset = 1.

## Timing
- Reset values:
  - acc = 0, active_inc = 0, shadow_inc = 0, pending = 0
  - phase_out = 0, square_out = 0, wrap_pulse = 0, inc_ready = 1
- Handshake at edge N: inc_ready is low after N. Commit is no earlier than edge N+1. The new increment affects acc from edge N+2 or later.
- With active_inc = 0 and a handshake at edge N: commit at N+1, first advance by the new value at N+2.
- wrap_pulse is high for exactly the cycle after the edge whose addition carried.
- Wrap period for a constant increment I ≠ 0: floor or ceil of 2^ACC_WIDTH / I enabled cycles.
- Latency from an acc update to phase_out/square_out is 0 (direct register slices).

## Configuration
- NCO_DITHER_EN defined: adds a 16-bit Fibonacci LFSR.
  - Polynomial x^16+x^14+x^13+x^11+1.
  - Seed 16'hACE1 on reset.
  - Advances once per enabled cycle.
  - phase_out = top PHASE_WIDTH bits of (acc + lfsr[ACC_WIDTH-PHASE_WIDTH-1:0]), modulo 2^ACC_WIDTH.
  - acc, square_out and wrap_pulse are unaffected.
- NCO_DITHER_EN undefined: no LFSR logic. phase_out is the plain acc slice.

## Test plan
All scenarios use default parameters, NCO_DITHER_EN undefined except scenario 6.
1. Reset held 3 cycles, then released with inc_valid = 0 -> all outputs 0, inc_ready = 1, acc stays 0 with enable = 1.
2. inc_in = 4096 accepted, enable = 1 -> commit next cycle. phase_out increments every 16 cycles. wrap_pulse is a single cycle every 4096 cycles. square_out toggles every 2048 cycles.
3. Running at 4096, then inc_in = 2441 accepted mid-period -> inc_ready low until the next wrap. Step 4096 is kept through the wrap, then step 2441. No phase discontinuity.
4. Handshake asserted in the same cycle as a carry -> the value waits for the following wrap (4096 cycles later) before committing.
5. enable = 0 for 10 cycles with a pending value -> acc frozen and commit within 1 cycle. Pulse reset mid-period -> all state reset, shadow discarded, inc_ready = 1.
6. NCO_DITHER_EN defined, inc = 4096 -> wrap_pulse timing identical to scenario 2. Each phase_out value differs from the plain slice by at most +1 code, modulo 2^PHASE_WIDTH.
